stack_master: RTL
=================

# stack_master

Command-driven master for the 8-bit hardware stack. Accepts one stack-machine instruction at a time over a valid/ready handshake and sequences the push/pop/tos strobes plus data on the stack's port. Performs 8-bit ALU work on popped operands and tracks stack depth to reject underflow and overflow. Sits between the instruction decoder and the stack in the stack-based datapath.

## Interface

- DEPTH, 8: stack capacity in entries; sets the overflow limit and the width of `depth`, which is clog2(DEPTH+1).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_op  in  3  opcode:
  - 000 NOP
  - 001 PUSH
  - 010 POP
  - 011 ADD
  - 100 SUB
  - 101 AND
  - 110 NOT
  - 111 DUP
- cmd_imm  in  8  immediate operand for PUSH.
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  valid with `done`; high when the command was rejected.
- result  out  8  value popped (POP), computed (ADD/SUB/AND/NOT), or copied (DUP). Held until the next `done`.
- depth  out  clog2(DEPTH+1)  current entry count.
- stk_push, stk_pop, stk_tos  out  1  stack strobes; at most one is high in any cycle.
- stk_data_in  out  8  data driven to the stack on push.
- stk_data_out  in  8  stack read data; valid the cycle after a pop or tos strobe edge.

## Operation

- States: IDLE, POP_A, CAP_A, POP_B, CAP_B, TOS, CAP_T, PUSH_R, DONE.
- Strobes and `cmd_ready` are Moore decodes of the state:
  - POP_A and POP_B drive `stk_pop`.
  - TOS drives `stk_tos`.
  - PUSH_R drives `stk_push`, with `stk_data_in` = r (internal result register).
- IDLE, on cmd_valid & cmd_ready:
  - Latch op and imm.
  - Legality check uses `depth` at accept:
    - PUSH and DUP need depth < DEPTH.
    - POP, NOT and DUP need depth ≥ 1.
    - ADD, SUB and AND need depth ≥ 2.
  - Illegal: go to DONE with err=1; no strobes; depth and result unchanged.
  - NOP: go to DONE with err=0.
  - PUSH: r ← imm, go to PUSH_R.
  - POP, ADD, SUB, AND, NOT: go to POP_A.
  - DUP: go to TOS.
- POP_A → CAP_A. CAP_A latches a ← stk_data_out, then:
  - POP: result ← a, go to DONE.
  - NOT: r ← ~a, result ← ~a, go to PUSH_R.
  - ADD, SUB, AND: go to POP_B.
- POP_B → CAP_B. CAP_B latches b ← stk_data_out, computes r, sets result ← r, goes to PUSH_R.
  - ADD: b + a.
  - SUB: b − a (deeper entry minus top).
  - AND: b & a.
  - Arithmetic is 8-bit modulo 256; carry and borrow are discarded.
- TOS → CAP_T. CAP_T sets r ← stk_data_out and result ← stk_data_out, then goes to PUSH_R.
- PUSH_R → DONE.
- DONE: done=1, err as decided at accept; then go to IDLE.
- depth updates on the edge ending each strobe cycle: +1 in PUSH_R, −1 in POP_A and POP_B.
- Commands presented while cmd_ready=0 are not accepted; the upstream holds them.

## Timing

- Reset: state IDLE; depth 0; result, r, a, b all 0; done, err and every strobe 0; stk_data_in 0. The stack must share `rst`.
- Latency from accept edge to `done` cycle:
  - NOP or rejected: 1.
  - PUSH: 2.
  - POP: 3.
  - DUP: 4.
  - NOT: 4.
  - ADD, SUB, AND: 6.
- Throughput: the next command is accepted in the cycle after `done`. cmd_ready is already high in that cycle.
- Reset asserted mid-command aborts immediately: strobes drop asynchronously and no partial push completes.
- cmd_valid held high across `done` is accepted on the first IDLE cycle.
- At depth=DEPTH, PUSH and DUP are rejected. Binary ops and NOT remain legal: net −1 and 0 entries respectively.
- At depth=0, every op except PUSH and NOP is rejected.

## Test plan

- Reset, then PUSH 0x12, PUSH 0x34, ADD → one `stk_push` with 0x12, then one with 0x34; ADD gives result=0x46, depth=1, done 6 cycles after accept, err=0.
- PUSH 0x05, PUSH 0x07, SUB → result=0xFE (5−7 mod 256), depth=1; PUSH 0xF0, AND → result=0xF0 & 0xFE = 0xF0.
- PUSH 0xA5, DUP, POP, POP → DUP result=0xA5, depth goes 1→2→1→0; both POPs return 0xA5; NOT at depth 0 → err=1, no strobe, depth stays 0.
- PUSH 8 times (DEPTH=8), then PUSH 0x99 → err=1, stk_push never asserted for 0x99, depth=8; then NOT → result = ~top, depth=8.
- Assert rst during POP_B of an ADD → all strobes 0 that cycle; depth=0, result=0, cmd_ready=1 after rst release.
- Back-to-back: cmd_valid held high with PUSH 0x01 → accepted every 3 cycles; at most one of stk_push, stk_pop, stk_tos high in any cycle.

Source files
------------

// File: rtl/stack_master.sv
// rtl/stack_master.sv - instruction sequencer and 8-bit ALU in front of the hardware stack
// One command at a time; every strobe and handshake output is a flop set on entry to its state.
module stack_master #(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   input  logic [2:0]                   cmd_op,
   input  logic [7:0]                   cmd_imm,
   output logic                         cmd_ready,
   output logic                         done,
   output logic                         err,
   output logic [7:0]                   result,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         stk_push,
   output logic                         stk_pop,
   output logic                         stk_tos,
   output logic [7:0]                   stk_data_in,
   input  logic [7:0]                   stk_data_out
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] FULL = DW'(DEPTH);
   localparam logic [DW-1:0] TWO  = DW'(2);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_DUP  = 3'd7;

   typedef enum logic [3:0] {
      IDLE, POP_A, CAP_A, POP_B, CAP_B, TOS, CAP_T, PUSH_R, DONE
   } state_t;

   state_t     state;
   logic [2:0] op;
   logic [7:0] r;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] opnd_b;
   logic [7:0] alu;
   logic       legal;

   assign stk_data_in = r;

   // The deeper operand arrives on stk_data_out during CAP_B; b keeps it afterwards.
   assign opnd_b = (state == CAP_B) ? stk_data_out : b;

   always_comb begin
      alu = 8'h00;
      case (op)
         OP_ADD:  alu = opnd_b + a;
         OP_SUB:  alu = opnd_b - a;
         OP_AND:  alu = opnd_b & a;
         default: alu = 8'h00;
      endcase
   end

   always_comb begin
      legal = 1'b1;
      case (cmd_op)
         OP_PUSH:                legal = (depth < FULL);
         OP_DUP:                 legal = (depth < FULL) && (depth != '0);
         OP_POP, OP_NOT:         legal = (depth != '0);
         OP_ADD, OP_SUB, OP_AND: legal = (depth >= TWO);
         default:                legal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op        <= OP_NOP;
         r         <= 8'h00;
         a         <= 8'h00;
         b         <= 8'h00;
         result    <= 8'h00;
         depth     <= '0;
         err       <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
         stk_push  <= 1'b0;
         stk_pop   <= 1'b0;
         stk_tos   <= 1'b0;
      end else begin
         done      <= 1'b0;
         cmd_ready <= 1'b0;
         stk_push  <= 1'b0;
         stk_pop   <= 1'b0;
         stk_tos   <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op  <= cmd_op;
                  err <= !legal;
                  if (!legal || cmd_op == OP_NOP) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     case (cmd_op)
                        OP_PUSH: begin
                           r        <= cmd_imm;
                           state    <= PUSH_R;
                           stk_push <= 1'b1;
                        end
                        OP_DUP: begin
                           state   <= TOS;
                           stk_tos <= 1'b1;
                        end
                        default: begin
                           state   <= POP_A;
                           stk_pop <= 1'b1;
                        end
                     endcase
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            POP_A: begin
               depth <= depth - 1'b1;
               state <= CAP_A;
            end
            CAP_A: begin
               a <= stk_data_out;
               case (op)
                  OP_POP: begin
                     result <= stk_data_out;
                     state  <= DONE;
                     done   <= 1'b1;
                  end
                  OP_NOT: begin
                     r        <= ~stk_data_out;
                     result   <= ~stk_data_out;
                     state    <= PUSH_R;
                     stk_push <= 1'b1;
                  end
                  default: begin
                     state   <= POP_B;
                     stk_pop <= 1'b1;
                  end
               endcase
            end
            POP_B: begin
               depth <= depth - 1'b1;
               state <= CAP_B;
            end
            CAP_B: begin
               b        <= stk_data_out;
               r        <= alu;
               result   <= alu;
               state    <= PUSH_R;
               stk_push <= 1'b1;
            end
            TOS: begin
               state <= CAP_T;
            end
            CAP_T: begin
               r        <= stk_data_out;
               result   <= stk_data_out;
               state    <= PUSH_R;
               stk_push <= 1'b1;
            end
            PUSH_R: begin
               depth <= depth + 1'b1;
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
